// File: rtl/corr_lag_bank.sv
// Multi-lag 1-bit sign correlator: LAGS saturating accumulators with period dump
// and a sequential peak-magnitude search over the dumped values.

module corr_lag_lane #(
    parameter int INTEG_W = 14,
    parameter int OUT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_match,
    input  logic             i_clr,
    output logic [OUT_W-1:0] o_snap,
    output logic             o_sat
);
    localparam logic [INTEG_W-1:0] ACC_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
    localparam logic [INTEG_W-1:0] ACC_MIN = {1'b1, {(INTEG_W-2){1'b0}}, 1'b1};

    logic [INTEG_W-1:0] r_acc;
    logic [INTEG_W-1:0] w_acc_nxt;

    always_comb begin
        w_acc_nxt = r_acc;
        o_sat     = 1'b0;
        if (i_en) begin
            if (i_match) begin
                if (r_acc == ACC_MAX) o_sat = 1'b1;
                else                  w_acc_nxt = r_acc + INTEG_W'(1);
            end else begin
                if (r_acc == ACC_MIN) o_sat = 1'b1;
                else                  w_acc_nxt = r_acc - INTEG_W'(1);
            end
        end
    end

    // Snapshot includes the sample accepted in the dump cycle.
    assign o_snap = w_acc_nxt[INTEG_W-1 -: OUT_W];

    always_ff @(posedge clk) begin
        if (rst || i_clr) r_acc <= '0;
        else              r_acc <= w_acc_nxt;
    end
endmodule

module corr_lag_bank #(
    parameter int LAGS        = 8,
    parameter int INTEG_W     = 14,
    parameter int OUT_W       = 8,
    parameter int AUTO_PERIOD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sig,
    input  logic                    code,
    input  logic                    dump,
    output logic [LAGS*OUT_W-1:0]   values,
    output logic                    valid,
    output logic                    overflow,
    output logic [$clog2(LAGS)-1:0] peak_idx,
    output logic [OUT_W-1:0]        peak_val,
    output logic                    peak_valid
);
    localparam int IDX_W = $clog2(LAGS);
    localparam int CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    logic                        r_sig, r_code, r_en;
    logic [LAGS-2:0]             r_dl;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_sticky;
    logic [LAGS-1:0][OUT_W-1:0]  r_val;
    logic                        r_valid, r_ovf;

    logic [LAGS-1:0]             w_tap, w_match, w_sat;
    logic [LAGS-1:0][OUT_W-1:0]  w_snap;
    logic                        w_auto, w_dump;

    // Lag 0 taps the current registered code; lag k sees it k accepted samples later.
    assign w_tap   = {r_dl, r_code};
    assign w_match = ~(w_tap ^ {LAGS{r_sig}});
    assign w_auto  = (AUTO_PERIOD > 0) && r_en && (r_cnt == CNT_W'(AUTO_PERIOD - 1));
    assign w_dump  = dump || w_auto;

    for (genvar k = 0; k < LAGS; k++) begin : g_lane
        corr_lag_lane #(.INTEG_W(INTEG_W), .OUT_W(OUT_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_en    (r_en),
            .i_match (w_match[k]),
            .i_clr   (w_dump),
            .o_snap  (w_snap[k]),
            .o_sat   (w_sat[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig    <= 1'b0;
            r_code   <= 1'b0;
            r_en     <= 1'b0;
            r_dl     <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_val    <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_sig   <= sig;
            r_code  <= code;
            r_en    <= en;
            r_valid <= w_dump;
            if (r_en) r_dl <= w_tap[LAGS-2:0];
            if (w_dump)    r_cnt <= '0;
            else if (r_en) r_cnt <= r_cnt + CNT_W'(1);
            if (w_dump) begin
                r_val    <= w_snap;
                r_ovf    <= r_sticky | (|w_sat);
                r_sticky <= 1'b0;
            end else begin
                r_sticky <= r_sticky | (|w_sat);
            end
        end
    end

    assign values   = r_val;
    assign valid    = r_valid;
    assign overflow = r_ovf;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx, r_best_idx, r_peak_idx;
    logic [OUT_W-1:0] r_best_val, r_peak_val;
    logic [OUT_W:0]   r_best_mag;
    logic             r_peak_valid;

    logic [OUT_W-1:0] w_cur;
    logic [OUT_W:0]   w_ext, w_mag;
    logic             w_take;

    // One extra bit so the most negative value has a representable magnitude.
    assign w_cur  = r_val[r_idx];
    assign w_ext  = {w_cur[OUT_W-1], w_cur};
    assign w_mag  = w_cur[OUT_W-1] ? -w_ext : w_ext;
    assign w_take = (r_idx == '0) || (w_mag > r_best_mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_val   <= '0;
            r_best_mag   <= '0;
            r_peak_idx   <= '0;
            r_peak_val   <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            if (r_valid) begin
                r_state <= S_SCAN;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    S_SCAN: begin
                        if (w_take) begin
                            r_best_idx <= r_idx;
                            r_best_val <= w_cur;
                            r_best_mag <= w_mag;
                        end
                        if (r_idx == IDX_W'(LAGS - 1)) begin
                            r_state      <= S_DONE;
                            r_peak_idx   <= w_take ? r_idx : r_best_idx;
                            r_peak_val   <= w_take ? w_cur : r_best_val;
                            r_peak_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign peak_idx   = r_peak_idx;
    assign peak_val   = r_peak_val;
    assign peak_valid = r_peak_valid;
endmodule

// File: tb/tb_corr_lag_bank.sv
// Directed + random bench for corr_lag_bank against a sample-history correlation model.

module tb_corr_lag_bank;
    localparam int LAGS    = 8;
    localparam int INTEG_W = 14;
    localparam int OUT_W   = 8;
    localparam int SH      = INTEG_W - OUT_W;
    localparam int AMAX    = 2**(INTEG_W-1) - 1;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, sig = 1'b0, code = 1'b0, dump = 1'b0;
    logic nodump = 1'b0;
    logic [LAGS*OUT_W-1:0] values, values2;
    logic valid, overflow, peak_valid, valid2, overflow2, peak_valid2;
    logic [2:0] peak_idx, peak_idx2;
    logic [OUT_W-1:0] peak_val, peak_val2;

    corr_lag_bank #(.LAGS(LAGS), .INTEG_W(INTEG_W), .OUT_W(OUT_W), .AUTO_PERIOD(0)) dut (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .code(code), .dump(dump),
        .values(values), .valid(valid), .overflow(overflow),
        .peak_idx(peak_idx), .peak_val(peak_val), .peak_valid(peak_valid));

    corr_lag_bank #(.LAGS(LAGS), .INTEG_W(INTEG_W), .OUT_W(OUT_W), .AUTO_PERIOD(256)) dut2 (
        .clk(clk), .rst(rst), .en(en), .sig(sig), .code(code), .dump(nodump),
        .values(values2), .valid(valid2), .overflow(overflow2),
        .peak_idx(peak_idx2), .peak_val(peak_val2), .peak_valid(peak_valid2));

    always #5 clk = ~clk;

    int ncmp = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: accepted code history (newest first) and per-lag sums.
    int m_acc[LAGS];
    bit m_hist[$];
    bit p_en, p_sig, p_code, m_ovf, e_ovf;
    logic [LAGS*OUT_W-1:0] e_vals;
    logic [OUT_W-1:0] pend_val, e_pval;
    int pend_idx, e_pidx;
    int due = -1, tick = 0, npv = 0, npv2 = 0;
    int v2_ticks[$];
    logic [63:0] v2_vals[$];

    task automatic cyc(input bit r, input bit e, input bit s, input bit c, input bit d);
        bit ev, epv, tap;
        int v, bmag, mag;
        rst = r; en = e; sig = s; code = c; dump = d;
        @(posedge clk);
        @(negedge clk);
        ev = 0; epv = 0;
        if (r) begin
            for (int k = 0; k < LAGS; k++) m_acc[k] = 0;
            m_hist.delete();
            p_en = 0; p_sig = 0; p_code = 0;
            m_ovf = 0; e_ovf = 0; e_vals = '0;
            e_pidx = 0; e_pval = '0; due = -1;
        end else begin
            if (tick == due) begin
                epv = 1; e_pidx = pend_idx; e_pval = pend_val;
            end
            if (p_en) begin
                m_hist.push_front(p_code);
                if (m_hist.size() > LAGS) void'(m_hist.pop_back());
                for (int k = 0; k < LAGS; k++) begin
                    tap = (k < m_hist.size()) ? m_hist[k] : 1'b0;
                    v = m_acc[k] + ((p_sig == tap) ? 1 : -1);
                    if (v > AMAX) begin v = AMAX; m_ovf = 1; end
                    else if (v < -AMAX) begin v = -AMAX; m_ovf = 1; end
                    m_acc[k] = v;
                end
            end
            if (d) begin
                ev = 1; e_ovf = m_ovf; m_ovf = 0;
                bmag = -1;
                for (int k = 0; k < LAGS; k++) begin
                    e_vals[k*OUT_W +: OUT_W] = OUT_W'(m_acc[k] >>> SH);
                    m_acc[k] = 0;
                    v = $signed(e_vals[k*OUT_W +: OUT_W]);
                    mag = (v < 0) ? -v : v;
                    if (mag > bmag) begin
                        bmag = mag; pend_idx = k; pend_val = e_vals[k*OUT_W +: OUT_W];
                    end
                end
                due = tick + LAGS + 1;
            end
            p_en = e; p_sig = s; p_code = c;
        end
        chk("valid", valid, ev);
        chk("peak_valid", peak_valid, epv);
        if (ev || r) begin
            chk("values", values, e_vals);
            chk("overflow", overflow, e_ovf);
        end
        if (epv || r) begin
            chk("peak_idx", peak_idx, e_pidx);
            chk("peak_val", peak_val, e_pval);
        end
        if (peak_valid) npv++;
        if (peak_valid2) npv2++;
        if (valid2) begin
            v2_ticks.push_back(tick);
            v2_vals.push_back(values2);
        end
        tick++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    // 63-chip m-sequence on code, sig = code delayed 3; needs a cleared delay line.
    task automatic run_lag3(input string tag);
        logic [5:0] lf;
        logic [3:0] sh;
        bit c;
        lf = 6'd1; sh = '0;
        repeat (1024) begin
            c  = lf[5];
            lf = {lf[4:0], lf[5] ^ lf[4]};
            cyc(0, 1, sh[2], c, 0);
            sh = {sh[2:0], c};
        end
        cyc(0, 0, 0, 0, 1);
        chk({tag, "_lag3"}, values[3*OUT_W +: OUT_W], 8'd16);
        idle(9);
        chk({tag, "_peak"}, {peak_valid, peak_idx, peak_val}, {1'b1, 3'd3, 8'd16});
        idle(2);
    endtask

    initial begin
        int n0, a, n;
        bit c;
        logic [2:0] pat;
        @(negedge clk);
        repeat (3) cyc(1, 0, 0, 0, 0);

        run_lag3("s1");

        repeat (1024) begin
            c = 1'($urandom);
            cyc(0, 1, ~c, c, 0);
        end
        cyc(0, 0, 0, 0, 1);
        chk("s2_lag0", values[OUT_W-1:0], 8'hF0);
        chk("s2_ovf", overflow, 1'b0);
        idle(9);
        chk("s2_peak", {peak_valid, peak_idx, peak_val}, {1'b1, 3'd0, 8'hF0});

        repeat (9000) cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("s3_sat_vals", values, {LAGS{8'h7F}});
        chk("s3_sat_ovf", overflow, 1'b1);
        idle(10);
        repeat (64) cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("s3_next_vals", values, {LAGS{8'h01}});
        chk("s3_next_ovf", overflow, 1'b0);
        idle(10);

        repeat (64) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("s4_incl", values[OUT_W-1:0], 8'h01);
        cyc(0, 0, 0, 0, 1);
        chk("s4_b2b_zero", values, '0);
        idle(10);

        n0 = npv;
        repeat (200) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
        cyc(0, 0, 0, 0, 1);
        repeat (2) cyc(0, 1, 1'($urandom), 1'($urandom), 0);
        cyc(0, 0, 0, 0, 1);
        idle(20);
        chk("s5_one_peak", npv - n0, 1);

        // Period-3 code makes lags 2 and 5 identical: equal magnitudes.
        pat = 3'b011; n = 0;
        repeat (96) begin cyc(0, 1, pat[(n+1)%3], pat[n%3], 0); n++; end
        cyc(0, 0, 0, 0, 1);
        idle(10);
        repeat (192) begin cyc(0, 1, pat[(n+1)%3], pat[n%3], 0); n++; end
        cyc(0, 0, 0, 0, 1);
        idle(9);
        chk("s5_tie", {peak_valid, peak_idx, peak_val}, {1'b1, 3'd2, 8'd3});
        idle(2);

        repeat (3000)
            cyc(0, $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), $urandom_range(0, 49) == 0);
        idle(12);

        repeat (100) cyc(0, 1, 1'($urandom), 1'($urandom), 0);
        cyc(1, 0, 0, 0, 0);
        idle(2);
        repeat (50) cyc(0, 1, 1'($urandom), 1'($urandom), 0);
        cyc(0, 0, 0, 0, 1);
        idle(4);
        cyc(1, 0, 0, 0, 0);
        n0 = npv;
        idle(15);
        chk("s6_no_peak", npv - n0, 0);
        run_lag3("s6");

        cyc(1, 0, 0, 0, 0);
        v2_ticks.delete();
        v2_vals.delete();
        n0 = npv2;
        a = tick;
        repeat (800) cyc(0, 1, 0, 0, 0);
        chk("auto_count", v2_ticks.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < v2_ticks.size()) begin
                chk("auto_tick", v2_ticks[i], a + 256 * (i + 1));
                chk("auto_vals", v2_vals[i], {LAGS{8'h04}});
            end
        end
        chk("auto_peaks", npv2 - n0, 3);
        chk("auto_peakout", {overflow2, peak_idx2, peak_val2}, {1'b0, 3'd0, 8'd4});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
